// File: rtl/l0mdt_dataformats_svh.sv
// Shared L0MDT data-format constants used by the MTC2SL link receiver.
// MTC2SL_LEN        : width of one MTC2SL link word, valid flag included.
// MTC2SL_VALID_BIT  : index of the valid flag inside an MTC2SL word (the MSB).
package l0mdt_dataformats_svh;

  localparam int MTC2SL_LEN       = 32;
  localparam int MTC2SL_VALID_BIT = MTC2SL_LEN - 1;

endpackage

// File: rtl/mtc2sl_link_receiver_pkg.sv
// Helpers shared by the MTC2SL link receiver, its stream interface and its bench.
// link_width(n) : bits needed to carry a link index for n links (minimum 1).
package mtc2sl_link_receiver_pkg;

  function automatic int link_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mtc2sl_link_receiver_if.sv
// Merged ready/valid stream leaving the MTC2SL link receiver.
// data  : payload, link valid flag already stripped
// link  : index of the source link
// valid : word present on data/link
// ready : downstream accepts the word on this edge
// master drives data/link/valid, slave drives ready.
interface mtc2sl_link_receiver_if #(
  parameter int DATA_W = 31,
  parameter int LINK_W = 2
);

  logic [DATA_W-1:0] data;
  logic [LINK_W-1:0] link;
  logic              valid;
  logic              ready;

  modport master (output data, output link, output valid, input ready);
  modport slave  (input data, input link, input valid, output ready);

endinterface

// File: rtl/mtc2sl_link_receiver_mtc_rx_fifo.sv
// Synchronous single-clock FIFO holding words of one MTC2SL link.
// clock, rst : clock and synchronous active-high flush
// push, din  : write request and word; ignored while full
// pop        : read request; ignored while empty
// dout       : head word, visible combinationally while not empty
// full/empty : occupancy flags derived from the registered pointers
module mtc_rx_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only and is never cleared; the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mtc2sl_link_receiver.sv
// Sector-logic-side receiver for the MTC2SL links.
// Each link word with its MSB set is captured into a per-link FIFO; the FIFOs
// are merged round-robin into one ready/valid stream tagged with the link index.
// clock, rst, srst : clock, synchronous active-high reset and soft reset (same effect)
// mtc2sl_in        : one word per link per cycle, MSB is the valid flag
// merged           : output stream (data, link, valid driven here; ready from downstream)
// rx_cnt, ovf_cnt  : per-link saturating counts of accepted / dropped words
// fifo_empty       : per-link registered FIFO empty flags
module mtc2sl_link_receiver
  import l0mdt_dataformats_svh::*;
  import mtc2sl_link_receiver_pkg::*;
#(
  parameter int N_LINKS      = 3,
  parameter int MTC2SL_WIDTH = MTC2SL_LEN,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    srst,
  input  logic [MTC2SL_WIDTH-1:0] mtc2sl_in [N_LINKS],
  mtc2sl_link_receiver_if.master  merged,
  output logic [CNT_WIDTH-1:0]    rx_cnt    [N_LINKS],
  output logic [CNT_WIDTH-1:0]    ovf_cnt   [N_LINKS],
  output logic [N_LINKS-1:0]      fifo_empty
);

  localparam int LINK_W = link_width(N_LINKS);
  localparam int PAY_W  = MTC2SL_WIDTH - 1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // (base + off) mod N_LINKS, with off < N_LINKS.
  function automatic logic [LINK_W-1:0] wrap_add(input logic [LINK_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_LINKS) s = s - N_LINKS;
    return LINK_W'(s);
  endfunction

  logic                    flush;
  logic [N_LINKS-1:0]      full;
  logic [N_LINKS-1:0]      empty_w;
  logic [N_LINKS-1:0]      pop;
  logic [PAY_W-1:0]        fifo_dout [N_LINKS];
  logic                    take;
  logic                    grant_any;
  logic [LINK_W-1:0]       grant_idx;
  logic [LINK_W-1:0]       cand;
  logic [LINK_W-1:0]       rr_ptr;
  logic [PAY_W-1:0]        data_p1;
  logic [LINK_W-1:0]       link_p1;
  logic                    vld_p1;

  assign flush      = rst | srst;
  assign fifo_empty = empty_w;

  // ---- stage p0: link capture into per-link FIFOs, statistics ----
  for (genvar k = 0; k < N_LINKS; k++) begin : g_link
    mtc_rx_fifo #(
      .WIDTH (PAY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock (clock),
      .rst   (flush),
      .push  (mtc2sl_in[k][MTC2SL_WIDTH-1]),
      .pop   (pop[k]),
      .din   (mtc2sl_in[k][PAY_W-1:0]),
      .dout  (fifo_dout[k]),
      .full  (full[k]),
      .empty (empty_w[k])
    );

    assign pop[k] = take && grant_any && (grant_idx == LINK_W'(k));

    // Full is judged on the start-of-cycle state, so a word meeting a full
    // FIFO is dropped even when that FIFO is popped on the same edge.
    always_ff @(posedge clock) begin
      if (flush) begin
        rx_cnt[k]  <= '0;
        ovf_cnt[k] <= '0;
      end else if (mtc2sl_in[k][MTC2SL_WIDTH-1]) begin
        if (full[k]) ovf_cnt[k] <= sat_inc(ovf_cnt[k]);
        else         rx_cnt[k]  <= sat_inc(rx_cnt[k]);
      end
    end
  end

  // ---- stage p0 -> p1: round-robin grant from rr_ptr upward ----
  assign take = !vld_p1 || merged.ready;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_LINKS; i++) begin
      cand = wrap_add(rr_ptr, i);
      if (!grant_any && !empty_w[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // ---- stage p1: output register ----
  // When nothing is granted the payload keeps its last value; only valid drops.
  always_ff @(posedge clock) begin
    if (flush) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      link_p1 <= '0;
      rr_ptr  <= '0;
    end else if (take) begin
      vld_p1 <= grant_any;
      if (grant_any) begin
        data_p1 <= fifo_dout[grant_idx];
        link_p1 <= grant_idx;
        rr_ptr  <= wrap_add(grant_idx, 1);
      end
    end
  end

  assign merged.data  = data_p1;
  assign merged.link  = link_p1;
  assign merged.valid = vld_p1;

endmodule
